// File: rtl/mc_hst_seq_if.sv
// rtl/mc_hst_seq_if.sv - host/memory handshake bundle for the host request sequencer
interface mc_hst_seq_if;
  logic        hst_arb_req;
  logic [22:0] hst_arb_addr;
  logic [1:0]  hst_arb_page;
  logic        hst_arb_read;
  logic        arb_busy;
  logic        hst_gnt;
  logic        mem_req;
  logic        mem_ack;
  logic [22:0] mem_addr;
  logic [1:0]  mem_len;
  logic        mem_read;
  logic        rd_valid;
  logic        wr_ready;
  logic        rc_push_en;
  logic        rc_pop_en;
  logic        seq_idle;
  logic        seq_err;
  logic        err_clr;

  modport master (
    input  hst_arb_req, hst_arb_addr, hst_arb_page, hst_arb_read, arb_busy,
    input  mem_ack, rd_valid, wr_ready, err_clr,
    output hst_gnt, mem_req, mem_addr, mem_len, mem_read,
    output rc_push_en, rc_pop_en, seq_idle, seq_err
  );

  modport slave (
    output hst_arb_req, hst_arb_addr, hst_arb_page, hst_arb_read, arb_busy,
    output mem_ack, rd_valid, wr_ready, err_clr,
    input  hst_gnt, mem_req, mem_addr, mem_len, mem_read,
    input  rc_push_en, rc_pop_en, seq_idle, seq_err
  );
endinterface

// File: rtl/mc_hst_seq.sv
// rtl/mc_hst_seq.sv - grants host requests, issues one burst command each, strobes beats back to the host stage
module mc_hst_seq #(
  parameter int TO_W      = 8,
  parameter int TO_CYCLES = 255
) (
  input  logic         mclock,
  input  logic         reset,
  mc_hst_seq_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_CMD,
    S_DATA,
    S_DONE
  } state_t;

  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TO_CYCLES - 1);

  state_t          state_q, state_d;
  logic [22:0]     addr_q, addr_d;
  logic [1:0]      len_q, len_d;
  logic            read_q, read_d;
  logic [1:0]      beat_q, beat_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic            pad_q, pad_d;
  logic            push_q, push_d;
  logic            pop_q, pop_d;
  logic            err_q, err_d;
  logic            err_set;
  logic            rd_ok;
  logic            wr_ok;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    read_d  = read_q;
    beat_d  = beat_q;
    wd_d    = wd_q;
    pad_d   = pad_q;
    push_d  = 1'b0;
    pop_d   = 1'b0;
    err_set = 1'b0;
    rd_ok   = 1'b0;
    wr_ok   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.hst_arb_req && !bus.arb_busy) begin
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        addr_d  = bus.hst_arb_addr;
        len_d   = bus.hst_arb_page;
        read_d  = bus.hst_arb_read;
        state_d = S_CMD;
      end
      S_CMD: begin
        if (bus.mem_ack) begin
          beat_d  = 2'd0;
          wd_d    = '0;
          pad_d   = 1'b0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (pad_q) begin
          // Timed-out read: synthesize the missing beats one per cycle.
          push_d = 1'b1;
          beat_d = beat_q + 2'd1;
          if (beat_q == len_q) begin
            pad_d   = 1'b0;
            state_d = S_DONE;
          end
        end else if (read_q ? bus.rd_valid : bus.wr_ready) begin
          rd_ok  = read_q;
          wr_ok  = !read_q;
          push_d = read_q;
          pop_d  = !read_q;
          beat_d = beat_q + 2'd1;
          wd_d   = '0;
          if (beat_q == len_q) begin
            state_d = S_DONE;
          end
        end else if (wd_q == WD_LAST) begin
          err_set = 1'b1;
          wd_d    = '0;
          if (read_q) begin
            pad_d = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          wd_d = wd_q + TO_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Any beat not consumed above is stray.
    if (bus.rd_valid && !rd_ok) begin
      err_set = 1'b1;
    end
    if (bus.wr_ready && !wr_ok) begin
      err_set = 1'b1;
    end

    if (err_set) begin
      err_d = 1'b1;
    end else if (bus.err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge mclock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      read_q  <= 1'b0;
      beat_q  <= '0;
      wd_q    <= '0;
      pad_q   <= 1'b0;
      push_q  <= 1'b0;
      pop_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      read_q  <= read_d;
      beat_q  <= beat_d;
      wd_q    <= wd_d;
      pad_q   <= pad_d;
      push_q  <= push_d;
      pop_q   <= pop_d;
      err_q   <= err_d;
    end
  end

  assign bus.hst_gnt    = (state_q == S_GRANT);
  assign bus.mem_req    = (state_q == S_CMD);
  assign bus.mem_addr   = addr_q;
  assign bus.mem_len    = len_q;
  assign bus.mem_read   = read_q;
  assign bus.rc_push_en = push_q;
  assign bus.rc_pop_en  = pop_q;
  assign bus.seq_idle   = (state_q == S_IDLE);
  assign bus.seq_err    = err_q;

endmodule

// File: tb/tb_mc_hst_seq.sv
// tb/tb_mc_hst_seq.sv - directed vector bench for mc_hst_seq
module tb_mc_hst_seq;

  typedef struct {
    logic        rd;
    logic [22:0] addr;
    int          ack_dly;
    logic [15:0] pat;
    int          exp_push;
    int          exp_pop;
    logic        exp_err;
    logic        chk_lag;
    logic        chk_pad;
  } vec_t;

  logic mclock = 1'b0;
  logic reset;

  mc_hst_seq_if bus();

  mc_hst_seq #(.TO_W(8), .TO_CYCLES(8)) dut (
    .mclock(mclock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 mclock = ~mclock;

  int n_tests = 0;
  int n_fail  = 0;

  int   cyc = 0;
  int   push_cnt = 0;
  int   pop_cnt = 0;
  int   lag_bad = 0;
  int   gnt_cnt = 0;
  int   push_cyc[8];
  int   last_strobe_cyc = 0;
  int   idle_rise_cyc = 0;
  int   gnt_prev_cyc = 0;
  int   gnt_last_cyc = 0;
  logic rd_prev = 1'b0;
  logic wr_prev = 1'b0;
  logic idle_prev = 1'b1;
  bit   chk_lag_en = 1'b0;

  vec_t vecs[8];

  always @(posedge mclock) cyc <= cyc + 1;

  always @(negedge mclock) begin
    if (bus.rc_push_en === 1'b1) begin
      push_cyc[push_cnt % 8] <= cyc;
      push_cnt <= push_cnt + 1;
    end
    if (bus.rc_pop_en === 1'b1) pop_cnt <= pop_cnt + 1;
    if (bus.rc_push_en === 1'b1 || bus.rc_pop_en === 1'b1) last_strobe_cyc <= cyc;
    if (bus.seq_idle === 1'b1 && !idle_prev) idle_rise_cyc <= cyc;
    if (bus.hst_gnt === 1'b1) begin
      gnt_prev_cyc <= gnt_last_cyc;
      gnt_last_cyc <= cyc;
      gnt_cnt <= gnt_cnt + 1;
    end
    if (chk_lag_en && ((bus.rc_push_en !== rd_prev) || (bus.rc_pop_en !== wr_prev)))
      lag_bad <= lag_bad + 1;
    rd_prev   <= bus.rd_valid;
    wr_prev   <= bus.wr_ready;
    idle_prev <= bus.seq_idle;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_gnt"},   bus.hst_gnt, 0);
    chk({nm, "_mreq"},  bus.mem_req, 0);
    chk({nm, "_maddr"}, bus.mem_addr, 0);
    chk({nm, "_mlen"},  bus.mem_len, 0);
    chk({nm, "_mrd"},   bus.mem_read, 0);
    chk({nm, "_push"},  bus.rc_push_en, 0);
    chk({nm, "_pop"},   bus.rc_pop_en, 0);
    chk({nm, "_idle"},  bus.seq_idle, 1);
    chk({nm, "_err"},   bus.seq_err, 0);
  endtask

  task automatic wait_gnt(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge mclock);
      if (bus.hst_gnt === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk({nm, "_gnt_seen"}, seen, 1);
  endtask

  task automatic wait_idle(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge mclock);
      if (bus.seq_idle === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk({nm, "_idle_seen"}, seen, 1);
    @(posedge mclock);
    #1;
  endtask

  // Entered just after the negedge of the GRANT cycle.
  task automatic do_cmd_data(input vec_t v, input string nm);
    @(negedge mclock);
    chk({nm, "_mem_req"},  bus.mem_req, 1);
    chk({nm, "_mem_addr"}, bus.mem_addr, v.addr);
    chk({nm, "_mem_len"},  bus.mem_len, v.rd ? 2'd3 : 2'd1);
    chk({nm, "_mem_read"}, bus.mem_read, v.rd);
    for (int i = 0; i < v.ack_dly; i++) begin
      @(negedge mclock);
      chk({nm, "_mem_req_held"}, bus.mem_req, 1);
    end
    bus.mem_ack = 1'b1;
    @(posedge mclock);
    #1;
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if ((v.pat >> i) == 16'd0) break;
      bus.rd_valid = v.rd & v.pat[i];
      bus.wr_ready = !v.rd & v.pat[i];
      @(posedge mclock);
      #1;
    end
    bus.rd_valid = 1'b0;
    bus.wr_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string nm = $sformatf("v%0d", idx);
    int p0 = push_cnt;
    int o0 = pop_cnt;
    int l0 = lag_bad;
    chk_lag_en = v.chk_lag;
    bus.hst_arb_req  = 1'b1;
    bus.hst_arb_addr = v.addr;
    bus.hst_arb_page = v.rd ? 2'd3 : 2'd1;
    bus.hst_arb_read = v.rd;
    wait_gnt(nm);
    bus.hst_arb_req = 1'b0;
    do_cmd_data(v, nm);
    wait_idle(nm);
    chk({nm, "_pushes"}, push_cnt - p0, v.exp_push);
    chk({nm, "_pops"},   pop_cnt - o0, v.exp_pop);
    chk({nm, "_err"},    bus.seq_err, v.exp_err);
    if (v.chk_lag) begin
      chk({nm, "_lag"}, lag_bad - l0, 0);
      chk({nm, "_idle_after_strobe"}, idle_rise_cyc - last_strobe_cyc, 1);
    end
    if (v.chk_pad && push_cnt >= 3)
      chk({nm, "_pad_consec"}, push_cyc[(push_cnt - 1) % 8] - push_cyc[(push_cnt - 3) % 8], 2);
    chk_lag_en = 1'b0;
    bus.err_clr = 1'b1;
    @(posedge mclock);
    #1;
    bus.err_clr = 1'b0;
    @(negedge mclock);
    chk({nm, "_err_clr"}, bus.seq_err, 0);
    @(posedge mclock);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   p0, g0, gap;

    //            rd    addr         ack pat       push pop err   lag   pad
    vecs[0] = '{1'b1, 23'h012345, 2, 16'h000F, 4, 0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 23'h000ABC, 0, 16'h0009, 0, 2, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 23'h7FFFFF, 1, 16'h0701, 4, 0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 23'h000000, 0, 16'h0780, 4, 0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 23'h055555, 3, 16'h0007, 0, 2, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 23'h02AAAA, 0, 16'h0001, 4, 0, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 23'h001001, 0, 16'h0001, 0, 1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 23'h040000, 1, 16'h0000, 0, 0, 1'b1, 1'b0, 1'b0};

    bus.hst_arb_req  = 1'b0;
    bus.hst_arb_addr = '0;
    bus.hst_arb_page = '0;
    bus.hst_arb_read = 1'b0;
    bus.arb_busy     = 1'b0;
    bus.mem_ack      = 1'b0;
    bus.rd_valid     = 1'b0;
    bus.wr_ready     = 1'b0;
    bus.err_clr      = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge mclock);
    @(negedge mclock);
    chk_reset_outputs("reset");
    reset = 1'b0;
    @(posedge mclock);
    #1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // arb_busy blocks the grant until it drops.
    g0 = gnt_cnt;
    bus.arb_busy     = 1'b1;
    bus.hst_arb_req  = 1'b1;
    bus.hst_arb_addr = 23'h00BEEF;
    bus.hst_arb_page = 2'd3;
    bus.hst_arb_read = 1'b1;
    repeat (10) @(posedge mclock);
    #1;
    chk("busy_no_gnt", gnt_cnt - g0, 0);
    bus.arb_busy = 1'b0;
    @(negedge mclock);
    chk("busy_fall_gnt0", bus.hst_gnt, 0);
    @(negedge mclock);
    chk("busy_fall_gnt1", bus.hst_gnt, 1);
    bus.hst_arb_req = 1'b0;
    p0 = push_cnt;
    v = '{1'b1, 23'h00BEEF, 1, 16'h000F, 4, 0, 1'b0, 1'b0, 1'b0};
    do_cmd_data(v, "busy");
    wait_idle("busy");
    chk("busy_pushes", push_cnt - p0, 4);

    // Stray beat in IDLE, then set-wins-over-clear.
    p0 = push_cnt;
    bus.rd_valid = 1'b1;
    @(posedge mclock);
    #1;
    bus.rd_valid = 1'b0;
    @(negedge mclock);
    chk("stray_rd_err", bus.seq_err, 1);
    bus.err_clr  = 1'b1;
    bus.wr_ready = 1'b1;
    @(posedge mclock);
    #1;
    bus.wr_ready = 1'b0;
    @(negedge mclock);
    chk("set_wins_err", bus.seq_err, 1);
    @(posedge mclock);
    #1;
    bus.err_clr = 1'b0;
    @(negedge mclock);
    chk("clr_err", bus.seq_err, 0);
    chk("stray_no_push", push_cnt - p0, 0);
    @(posedge mclock);
    #1;

    // Back-to-back requests with address changed after the first grant.
    p0 = push_cnt;
    bus.hst_arb_req  = 1'b1;
    bus.hst_arb_addr = 23'h000111;
    bus.hst_arb_page = 2'd3;
    bus.hst_arb_read = 1'b1;
    wait_gnt("b2b1");
    @(posedge mclock);
    #1;
    bus.hst_arb_addr = 23'h000222;
    v = '{1'b1, 23'h000111, 0, 16'h000F, 4, 0, 1'b0, 1'b0, 1'b0};
    do_cmd_data(v, "b2b1");
    wait_gnt("b2b2");
    @(posedge mclock);
    #1;
    bus.hst_arb_req = 1'b0;
    v = '{1'b1, 23'h000222, 2, 16'h000F, 4, 0, 1'b0, 1'b0, 1'b0};
    do_cmd_data(v, "b2b2");
    wait_idle("b2b2");
    chk("b2b_pushes", push_cnt - p0, 8);
    gap = gnt_last_cyc - gnt_prev_cyc;
    chk("b2b_gnt_gap_ge5", gap >= 5, 1);

    // Reset after two read beats abandons the burst.
    bus.hst_arb_req  = 1'b1;
    bus.hst_arb_addr = 23'h03AAAA;
    bus.hst_arb_page = 2'd3;
    bus.hst_arb_read = 1'b1;
    p0 = push_cnt;
    wait_gnt("rst");
    bus.hst_arb_req = 1'b0;
    @(negedge mclock);
    bus.mem_ack = 1'b1;
    @(posedge mclock);
    #1;
    bus.mem_ack  = 1'b0;
    bus.rd_valid = 1'b1;
    @(posedge mclock);
    #1;
    @(posedge mclock);
    #1;
    bus.rd_valid = 1'b0;
    @(negedge mclock);
    #1;
    reset = 1'b1;
    #1;
    chk_reset_outputs("rst_mid");
    @(posedge mclock);
    #1;
    chk("rst_pushes_before", push_cnt - p0, 2);
    p0 = push_cnt;
    repeat (2) @(posedge mclock);
    @(negedge mclock);
    reset = 1'b0;
    repeat (5) @(posedge mclock);
    #1;
    chk("rst_no_more_push", push_cnt - p0, 0);
    chk("rst_idle", bus.seq_idle, 1);
    v = '{1'b1, 23'h001234, 1, 16'h000F, 4, 0, 1'b0, 1'b1, 1'b0};
    run_vec(v, 99);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_hst_seq.md
# mc_hst_seq

Host request sequencer on the mclock side of the memory controller, directly downstream of the host capture/synchroniser stage. It grants host arbiter requests, forwards each as one burst command to the memory command path, and converts returned read beats and accepted write beats into the push/pop enables that the host stage counts to release its capture slots. A per-beat watchdog pads out stalled reads so the host stage can never deadlock.

## Interface
Parameters:
- TO_W, 8: watchdog counter width.
- TO_CYCLES, 255: idle cycles allowed between data beats before timeout; must be less than 2^TO_W.

Ports:
- mclock  in  1  memory controller clock.
- reset  in  1  asynchronous, active-high reset.
- hst_arb_req  in  1  host request pending.
- hst_arb_addr  in  23  host burst address.
- hst_arb_page  in  2  burst length minus one: 3 for read (4 beats), 1 for write (2 beats).
- hst_arb_read  in  1  1 = read, 0 = write.
- arb_busy  in  1  memory command path owned by another requester; blocks grant.
- hst_gnt  out  1  one-cycle grant pulse to the host stage.
- mem_req  out  1  burst command valid.
- mem_ack  in  1  command accepted.
- mem_addr  out  23  command address.
- mem_len  out  2  command length minus one.
- mem_read  out  1  command direction.
- rd_valid  in  1  read data beat returned.
- wr_ready  in  1  write data beat accepted.
- rc_push_en  out  1  read beat strobe to the host stage.
- rc_pop_en  out  1  write beat strobe to the host stage.
- seq_idle  out  1  sequencer in IDLE.
- seq_err  out  1  sticky error: timeout or stray beat.
- err_clr  in  1  clears seq_err.

## Operation
- States: IDLE, GRANT, CMD, DATA, DONE.
- IDLE: if hst_arb_req=1 and arb_busy=0, go to GRANT. Otherwise stay.
- GRANT: hst_gnt=1 for exactly one cycle. Latch hst_arb_addr, hst_arb_page and hst_arb_read into the command registers on the exit edge. Go to CMD.
- CMD: mem_req=1, with mem_addr/mem_len/mem_read driven from the latched values. When mem_ack=1 is sampled, clear the beat counter and watchdog, then go to DATA. mem_req is held until it is acknowledged.
- DATA, read: each rd_valid=1 cycle increments the 2-bit beat counter and produces rc_push_en=1 on the next cycle.
- DATA, write: each wr_ready=1 cycle increments the beat counter and produces rc_pop_en=1 on the next cycle.
- DATA exit: the beat for which the counter equals mem_len moves the FSM to DONE.
- DONE: one holdoff cycle, then IDLE.
- Watchdog: counts DATA cycles with no beat and resets on every beat. On reaching TO_CYCLES, set seq_err.
  - Read: generate one synthesized rc_push_en per cycle for the remaining beats, then go to DONE.
  - Write: go to DONE immediately with no pops.
- Stray beats: rd_valid or wr_ready outside DATA, or of the wrong direction, is ignored and sets seq_err.
- seq_err: cleared by err_clr=1 or reset. If a set event and err_clr occur together, set wins.
- seq_idle = (state==IDLE), combinational.
- Reset: state IDLE, command registers 0. Every output is 0 except seq_idle=1. Asserting reset mid-burst abandons the burst with no padding.

## Timing
- Request to grant: hst_arb_req sampled high in IDLE gives hst_gnt=1 in the next cycle (1-cycle latency).
- Grant to command: mem_req rises the cycle after hst_gnt.
- Beat to strobe: rc_push_en and rc_pop_en lag their beat by exactly one cycle. Back-to-back beats give back-to-back strobes.
- Grant spacing: at least 5 cycles between consecutive hst_gnt pulses (GRANT, CMD, at least one DATA cycle, DONE, IDLE). This covers the host stage's 2-cycle address update after a grant.
- Per burst: the read path emits exactly 4 rc_push_en pulses and the write path exactly 2 rc_pop_en pulses. The only exceptions are a write timeout (fewer pops) and reset.
- Wrap-around: the beat counter is 2 bits and wraps only after mem_len=3.
- hst_arb_req changes while in GRANT through DONE are ignored.

## Test plan
- Read burst: req, read=1, page=3, addr=0x12345; mem_ack 2 cycles after mem_req; 4 consecutive rd_valid -> one hst_gnt, mem_addr=0x12345, mem_len=3, 4 consecutive rc_push_en each 1 cycle after its beat, seq_idle back 2 cycles after the last beat.
- Write burst with gaps: page=1, wr_ready on cycles 0 and 3 of DATA -> exactly 2 rc_pop_en at cycles 1 and 4, no push, seq_err=0.
- arb_busy held 10 cycles with req high -> no hst_gnt during the hold; grant arrives the cycle after arb_busy falls.
- Read timeout: TO_CYCLES=8, only 1 rd_valid -> seq_err=1 and 3 synthesized rc_push_en on consecutive cycles (4 pushes total), then IDLE. err_clr then sets seq_err=0.
- Back-to-back requests: req held through two bursts -> two grants at least 5 cycles apart, with each command carrying its own latched address.
- Reset during DATA after 2 read beats -> all outputs 0 and seq_idle=1 immediately. No further pushes, and a new request afterwards is granted normally.
